// File: rtl/serial_output.sv
// UART transmitter: accepts 32-bit words on an stb/ack handshake and sends bits [7:0] as 8N1.
// Define SERIAL_OUTPUT_PARITY_EN to insert an even-parity bit (8E1 framing).
module serial_output #(
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int BAUD_RATE       = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in,
  input  logic        in_stb,
  output logic        in_ack,
  output logic        tx,
  output logic        busy
);

  localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    data_q, data_d;
  logic          tx_q, tx_d;
  logic          ack_q, ack_d;
  logic          busy_q, busy_d;
  logic          last;
  logic [2:0]    idx_nxt;

  // Only the low byte of each word goes on the line.
  logic unused_in_hi;
  assign unused_in_hi = ^in[31:8];

  assign last    = (cnt_q == CNT_LAST);
  assign idx_nxt = idx_q + 3'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    tx_d    = tx_q;
    ack_d   = ack_q;
    busy_d  = busy_q;

    if (state_q != S_IDLE) begin
      cnt_d = last ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (ack_q && in_stb) begin
          data_d  = in[7:0];
          ack_d   = 1'b0;
          busy_d  = 1'b1;
          tx_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_START;
        end else begin
          ack_d = 1'b1;
        end
      end
      S_START: begin
        if (last) begin
          tx_d    = data_q[0];
          idx_d   = 3'd0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (last) begin
          if (idx_q != 3'd7) begin
            idx_d = idx_nxt;
            tx_d  = data_q[idx_nxt];
          end else begin
`ifdef SERIAL_OUTPUT_PARITY_EN
            tx_d    = ^data_q;
            state_d = S_PARITY;
`else
            tx_d    = 1'b1;
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef SERIAL_OUTPUT_PARITY_EN
      S_PARITY: begin
        if (last) begin
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (last) begin
          ack_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      data_q  <= 8'd0;
      tx_q    <= 1'b1;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign tx     = tx_q;
  assign in_ack = ack_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_serial_output.sv
// Directed bench for serial_output at 4 clocks per bit, with a sampling UART receiver model.
module tb_serial_output;

  localparam int C = 4;
`ifdef SERIAL_OUTPUT_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] in_w = 32'd0;
  logic        in_stb = 1'b0;
  logic        in_ack;
  logic        tx;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  serial_output #(
    .CLOCK_FREQUENCY(460800),
    .BAUD_RATE      (115200)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .in    (in_w),
    .in_stb(in_stb),
    .in_ack(in_ack),
    .tx    (tx),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line bits in time order (bit 0 = start bit).
  function automatic logic [10:0] frame_of(input logic [7:0] b);
`ifdef SERIAL_OUTPUT_PARITY_EN
    return {1'b1, ^b, b, 1'b0};
`else
    return {1'b0, 1'b1, b, 1'b0};
`endif
  endfunction

  // Called just after a negedge; returns just after the negedge on which in_ack is back.
  task automatic send_frame(input logic [31:0] word, input bit keep,
                            output logic [10:0] obs, output int waited);
    int   lowcnt;
    int   glitches;
    logic prev;
    in_w     = word;
    in_stb   = 1'b1;
    waited   = 0;
    obs      = '0;
    lowcnt   = 0;
    glitches = 0;
    prev     = 1'b0;
    while (in_ack !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_wait", 32'(waited < 200), 32'd1);
    @(posedge clk);
    for (int k = 0; k <= NB * C; k++) begin
      @(negedge clk);
      if (k == 0) begin
        if (!keep) in_stb = 1'b0;
        chk("busy_in_frame", 32'(busy), 32'd1);
      end
      if (k < NB * C) begin
        if (in_ack === 1'b0) lowcnt++;
        if (k % C == C / 2) obs[k / C] = tx;
        if (k % C != 0 && tx !== prev) glitches++;
        prev = tx;
      end
    end
    chk("ack_low_clocks", 32'(lowcnt), 32'(NB * C));
    chk("ack_back", 32'(in_ack), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("bit_stable", 32'(glitches), 32'd0);
    chk("frame_bits", 32'(obs), 32'(frame_of(word[7:0])));
  endtask

  task automatic rx_check(input string tag, input logic [10:0] obs, input logic [7:0] exp);
    chk(tag, 32'(obs[8:1]), 32'(exp));
    chk("rx_framing", 32'({obs[0], obs[NB-1]}), 32'h1);
`ifdef SERIAL_OUTPUT_PARITY_EN
    chk("rx_parity", 32'(obs[9] ^ (^obs[8:1])), 32'd0);
`endif
  endtask

  logic [10:0] obs;
  int          waited;

  initial begin
    // Reset held for 5 clocks
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_ack", 32'(in_ack), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("ack_after_release", 32'(in_ack), 32'd1);
    chk("busy_after_release", 32'(busy), 32'd0);
    chk("tx_after_release", 32'(tx), 32'd1);

    // Single byte 0xA5: time-order line sequence 0,1,0,1,0,0,1,0,1,1
    send_frame(32'h0000_00A5, 1'b0, obs, waited);
    chk("a5_sequence", 32'(obs[9:0] & 10'h1FF), 32'(10'b0101001010 & 10'h1FF));
    chk("a5_stop", 32'(obs[NB-1]), 32'd1);
    rx_check("rx_a5", obs, 8'hA5);

    // Idle with in_stb low stays idle
    repeat (10) @(negedge clk);
    chk("idle_tx", 32'(tx), 32'd1);
    chk("idle_ack", 32'(in_ack), 32'd1);

    // Upper bits ignored
    send_frame(32'hFFFF_FF3C, 1'b0, obs, waited);
    rx_check("rx_3c", obs, 8'h3C);

    // Back-to-back: second accept one clock after in_ack rises
    send_frame(32'h0000_0041, 1'b1, obs, waited);
    rx_check("rx_A", obs, 8'h41);
    send_frame(32'h0000_0042, 1'b0, obs, waited);
    chk("b2b_wait", 32'(waited), 32'd0);
    rx_check("rx_B", obs, 8'h42);

    // Reset during data bit 3 (0xF0 has bit 3 = 0)
    in_w   = 32'h0000_00F0;
    in_stb = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_stb = 1'b0;
    repeat (4 * C + 1) @(negedge clk);
    chk("mid_bit3_low", 32'(tx), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_ack", 32'(in_ack), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_ack_release", 32'(in_ack), 32'd1);
    send_frame(32'h0000_0055, 1'b0, obs, waited);
    rx_check("rx_55", obs, 8'h55);

`ifdef SERIAL_OUTPUT_PARITY_EN
    send_frame(32'h0000_0007, 1'b0, obs, waited);
    chk("parity_07", 32'(obs[9]), 32'd1);
    send_frame(32'h0000_0003, 1'b0, obs, waited);
    chk("parity_03", 32'(obs[9]), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_output.md
Name: serial_output

Overview:
- UART transmitter that sits directly downstream of the processor's `output_rs232_tx` stream.
- Consumes 32-bit words on the stb/ack handshake and serialises bits [7:0] of each word as an 8N1 frame on the RS-232 TX pin (8E1 when parity is compiled in).
- Applies back-pressure to the processor through the ack line while a frame is in flight.

Parameters:
- CLOCK_FREQUENCY, 100000000: clk frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s. CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE, integer truncation (868 at defaults). CLKS_PER_BIT must be at least 2.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted); release is synchronous to clk upstream
- in  input  32  data word from the processor; only [7:0] is transmitted, [31:8] ignored
- in_stb  input  1  in is valid
- in_ack  output  1  block can accept a word; transfer occurs on a rising edge where in_stb and in_ack are both 1
- tx  output  1  serial line, idle high
- busy  output  1  high from word acceptance until the stop bit (or parity-mode stop bit) completes

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, tx=1, in_ack=0, busy=0.
  - Bit counter and baud counter cleared; data register cleared.
- All outputs are registered.
- First rising edge after rst goes high: in_ack becomes 1.
- States:
  - IDLE: tx=1, in_ack=1, busy=0. On an edge with in_stb=1 and in_ack=1:
    - latch in[7:0]
    - in_ack<=0, busy<=1, tx<=0
    - baud counter<=0, go to START
    - tx falls on the accepting edge itself.
  - START: hold tx=0 for CLKS_PER_BIT cycles (baud counter 0..CLKS_PER_BIT-1). At terminal count:
    - tx<=data[0], bit index<=0, counter<=0, go to DATA.
  - DATA: each bit held CLKS_PER_BIT cycles, LSB first. At terminal count:
    - if bit index<7: index+1, tx<=next bit
    - if index=7: go to PARITY if enabled, else STOP with tx<=1.
  - PARITY (feature only): hold the parity bit CLKS_PER_BIT cycles, then go to STOP with tx<=1.
  - STOP: hold tx=1 for CLKS_PER_BIT cycles. At terminal count:
    - go to IDLE, in_ack<=1, busy<=0.
- Frame length:
  - From the accepting edge to the edge that reasserts in_ack: exactly 10*CLKS_PER_BIT clocks (11*CLKS_PER_BIT with parity).
- Back-to-back words:
  - The next word is accepted at the earliest one clock after in_ack rises.
  - Minimum inter-frame idle time is therefore 1 clk of tx=1 beyond the stop bit.
- in_stb low in IDLE: remain idle indefinitely, tx=1.
- in, in_stb and in_ack are ignored while not in IDLE. No word is lost: the producer holds in_stb until it is acked.
- Baud counter: width ceil(log2(CLKS_PER_BIT)), wraps to 0 at CLKS_PER_BIT-1. No drift across frames because the counter restarts at every accept.
- Reset mid-frame:
  - tx returns to 1 immediately (async).
  - The partial frame is abandoned. A receiver sees a truncated frame or framing error, which is acceptable.
  - in_ack rises on the first edge after release.

Optional Feature:
- Macro: SERIAL_OUTPUT_PARITY_EN.
- Defined:
  - PARITY state is inserted between DATA and STOP.
  - Parity bit = XOR of data[7:0] (even parity).
  - Frame is 11 bits.
- Undefined:
  - PARITY state and its logic are absent.
  - Frame is 10 bits (8N1).

Test Plan:
- Reset: hold rst=0 5 clocks, then release -> tx=1 throughout, in_ack=0 during reset, in_ack=1 on first edge after release, busy=0.
- Single byte with CLKS_PER_BIT overridden to 4 (CLOCK_FREQUENCY=460800, BAUD_RATE=115200), in=0x000000A5 with in_stb pulsed -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit lasting 4 clocks. in_ack low for exactly 40 clocks.
- Upper bits ignored: in=0xFFFFFF3C -> transmitted byte decodes as 0x3C; a bench UART receiver model matches.
- Back-to-back: hold in_stb=1 with words 0x41 then 0x42 -> second accept occurs exactly 1 clock after in_ack reasserts; the receiver model decodes "AB" with no framing error.
- Reset mid-frame: assert rst during data bit 3 -> tx=1 within the same cycle (async); after release a new word 0x55 is transmitted correctly.
- Parity (SERIAL_OUTPUT_PARITY_EN defined, CLKS_PER_BIT=4): in=0x07 -> parity bit=1, frame 11 bits, in_ack low 44 clocks. in=0x03 -> parity bit=0.
